matrix_mem_seq: RTL
===================

Name: matrix_mem_seq

Overview:
- Command-level sequencer sitting directly upstream of the coprocessor's single-word memory access module (8-bit address, 16-bit data, start/done handshake).
- Converts one "load matrix" or "store matrix" command into NUM_WORDS consecutive word accesses at base, base+1, ...
- Exposes the whole matrix as a flat register to the coprocessor datapath.

Parameters:
- NUM_WORDS, 13, words per transfer (5x5 matrix of 8-bit elements, packed two per word, last word half-used); legal range 1..256.
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory word width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_store  in  1  1 = store (write buffer to memory), 0 = load.
- cmd_base  in  ADDR_W  first word address.
- store_data  in  NUM_WORDS*DATA_W  words to write; word i is bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse at end of command.
- err  out  1  one-cycle pulse; used only with the optional feature, otherwise tied 0.
- load_data  out  NUM_WORDS*DATA_W  captured words, same packing as store_data.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory write data.
- mem_start  out  1  to memory start.
- mem_wr  out  1  to memory write enable.
- mem_data_out  in  DATA_W  from memory read data.
- mem_done  in  1  from memory done.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; load_data=0; state IDLE; index=0. Reset applies at any time, including mid-transfer: mem_start drops immediately and the partial transfer is discarded. Memory contents already written are not rolled back.
- States: IDLE, REQ, GAP, FIN.
- IDLE:
  - cmd_valid && cmd_ready accepts the command: latch cmd_store, cmd_base and store_data (snapshot); index<=0; busy<=1; go to REQ.
  - Commands while not IDLE are ignored; there is no queue.
- REQ:
  - mem_start=1; mem_wr=latched cmd_store; mem_address=(base+index) mod 2^ADDR_W (wraps 255->0); mem_data_in=latched word[index].
  - All four outputs are registered and stable for the whole REQ.
  - Wait indefinitely for mem_done=1. On that edge: if load, capture mem_data_out into load_data word[index]; go to GAP.
- GAP:
  - Exactly one cycle with mem_start=0, which lets memory clear its internal counter and done.
  - If index==NUM_WORDS-1, go to FIN; else index<=index+1 and go to REQ.
- FIN: done=1 for one cycle, busy<=0, then IDLE. cmd_ready returns the cycle after done.
- load_data words not yet captured keep their previous values. A store never modifies load_data.
- Timing: mem_start must never stay high across two accesses. Per-word cost = memory latency (start-to-done) + 1 GAP cycle. With the current 4-cycle memory latency, one word takes 5 cycles.
- Total command latency, accept to done pulse = NUM_WORDS*(Lmem+1) + 1 cycles.
- mem_done seen outside REQ is ignored.

Optional Feature:
- Macro MATRIX_MEM_SEQ_BOUNDS_CHECK_EN.
- When defined: at accept, if cmd_base + NUM_WORDS - 1 > 2^ADDR_W - 1, the command is rejected.
  - Behaviour: go IDLE->FIN directly; err and done both pulse in the same cycle; no mem_start; load_data unchanged.
- When undefined: no check, addresses wrap modulo 2^ADDR_W, err is tied to 0.

Decomposition:
- Shared package matrix_pkg: state encoding constants (IDLE=2'd0, REQ=2'd1, GAP=2'd2, FIN=2'd3), default NUM_WORDS=13, ADDR_W=8, DATA_W=16.
- One natural sub-module: matrix_word_mux, a combinational slice selector for word[index] out of the flat store buffer. Capture into load_data stays inline.

Test Plan:
- Load, base=8'h10, memory preloaded with words 16'h0100+i at addresses 0x10..0x1C (using the real memory module) -> load_data word i = 16'h0100+i for i=0..12; exactly 13 mem_start rising edges; done pulse 66 cycles after accept with 4-cycle memory.
- Store, base=8'h40, store_data word i = 16'hA000+i; then load from 0x40 -> readback identical; mem_wr=1 throughout the store; each mem_start low for exactly 1 cycle between words.
- Wrap, base=8'hF8, load, macro undefined -> addresses F8..FF then 00..04 in order; err stays 0.
- Same stimulus as the wrap test with MATRIX_MEM_SEQ_BOUNDS_CHECK_EN defined -> err and done pulse together 1 cycle after accept; no mem_start; load_data unchanged.
- reset asserted while in REQ at word 5 of a load -> same-cycle mem_start=0, busy=0, cmd_ready=1, load_data=0. A new load afterwards completes normally.
- cmd_valid held high during a busy transfer, with a different cmd_base -> ignored; memory-side model delaying mem_done by 20 extra cycles -> sequencer waits, with no timeout and no lost words.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state encoding and default sizes for the matrix sequencer
// Purpose: FSM state type and default parameter values used by matrix_mem_seq
//          and matrix_word_mux.
// Ports:   none (package).
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int DEF_NUM_WORDS = 13;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 16;

endpackage

// File: rtl/matrix_word_mux.sv
// rtl/matrix_word_mux.sv - combinational word selector for a flat word buffer
// Purpose: returns word[sel] of a flat NUM_WORDS*DATA_W vector; zero when sel
//          is beyond the last word.
// Ports:   words in  NUM_WORDS*DATA_W  flat buffer, word i at [DATA_W*i +: DATA_W]
//          sel   in  SEL_W             word index
//          word  out DATA_W            selected word
module matrix_word_mux
    import matrix_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SEL_W     = 4
) (
    input  logic [NUM_WORDS*DATA_W-1:0] words,
    input  logic [SEL_W-1:0]            sel,
    output logic [DATA_W-1:0]           word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (sel == SEL_W'(i)) begin
                word = words[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/matrix_mem_seq.sv
// rtl/matrix_mem_seq.sv - load/store matrix command sequencer over a single-word memory port
// Purpose: turns one load/store command into NUM_WORDS word accesses at
//          base, base+1, ... (address wraps modulo 2^ADDR_W) and exposes the
//          loaded matrix as a flat register.
// Optional: define MATRIX_MEM_SEQ_BOUNDS_CHECK_EN to reject commands whose
//          address range would run past the top of memory (err + done pulse).
// Ports:   clk, reset (async, active high)
//          cmd_valid, cmd_store, cmd_base, store_data   command side
//          cmd_ready, busy, done, err, load_data         status / result
//          mem_address, mem_data_in, mem_start, mem_wr   to memory
//          mem_data_out, mem_done                        from memory
module matrix_mem_seq
    import matrix_pkg::*;
#(
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    input  logic                        cmd_store,
    input  logic [ADDR_W-1:0]           cmd_base,
    input  logic [NUM_WORDS*DATA_W-1:0] store_data,
    output logic                        cmd_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [NUM_WORDS*DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data_in,
    output logic                        mem_start,
    output logic                        mem_wr,
    input  logic [DATA_W-1:0]           mem_data_out,
    input  logic                        mem_done
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                      state;
    state_t                      state_next;
    logic [IDX_W-1:0]            index;
    logic [IDX_W-1:0]            index_inc;
    logic                        store_q;
    logic [ADDR_W-1:0]           base_q;
    logic [NUM_WORDS*DATA_W-1:0] buf_q;
    logic [DATA_W-1:0]           next_word;
    logic                        accept;
    logic                        reject;

    assign accept    = cmd_valid && cmd_ready;
    assign index_inc = index + IDX_W'(1);

`ifdef MATRIX_MEM_SEQ_BOUNDS_CHECK_EN
    assign reject = accept && ((int'(cmd_base) + NUM_WORDS - 1) > ((1 << ADDR_W) - 1));
`else
    assign reject = 1'b0;
`endif

    // Next word to present is picked from the snapshot, not the live input,
    // so the command source may change store_data once accepted.
    matrix_word_mux #(
        .NUM_WORDS (NUM_WORDS),
        .DATA_W    (DATA_W),
        .SEL_W     (IDX_W)
    ) u_word_mux (
        .words (buf_q),
        .sel   (index_inc),
        .word  (next_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = reject ? FIN : REQ;
            REQ:     if (mem_done) state_next = GAP;
            GAP:     state_next = (index == LAST_IDX) ? FIN : REQ;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All status and memory-side outputs are registered from state_next so
    // they change exactly on the state transition and hold through REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_start   <= 1'b0;
            mem_wr      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            load_data   <= '0;
            index       <= '0;
            store_q     <= 1'b0;
            base_q      <= '0;
            buf_q       <= '0;
        end else begin
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            done      <= (state_next == FIN);
            err       <= reject;
            mem_start <= (state_next == REQ);
            mem_wr    <= (state_next == REQ) ? (accept ? cmd_store : store_q) : 1'b0;

            if (accept) begin
                store_q <= cmd_store;
                base_q  <= cmd_base;
                buf_q   <= store_data;
                index   <= '0;
            end

            if (accept && !reject) begin
                mem_address <= cmd_base;
                mem_data_in <= store_data[DATA_W-1:0];
            end else if (state == GAP && state_next == REQ) begin
                index       <= index_inc;
                mem_address <= base_q + ADDR_W'(index_inc);
                mem_data_in <= next_word;
            end

            if (state == REQ && mem_done && !store_q) begin
                load_data[int'(index)*DATA_W +: DATA_W] <= mem_data_out;
            end
        end
    end

endmodule
